// File: rtl/program_memory.sv
// ============================================================================
// Module   : program_memory
// Purpose  : Combinational instruction memory with a framed byte-serial loader
//            that holds the cpu in reset while a program image streams in.
//            Optional macro: PROGMEM_PRIV_PROTECT_EN (write-protects banks 1-3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_memory #(
  parameter int         ADDR_W    = 6,
  parameter int         DATA_W    = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              cpu_reset,
  output logic              busy,
  output logic              err
`ifdef PROGMEM_PRIV_PROTECT_EN
  ,
  input  logic              priv_unlock
`endif
);

  localparam int c_DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_mem [c_DEPTH];
  logic [ADDR_W-1:0]   r_wptr;
  logic [7:0]          r_cnt;
  logic [7:0]          r_sum;
  logic                r_err;
  logic                r_cpu_reset;
  logic                w_accept;
  logic                w_we;
  logic                w_write_ok;
  logic [7:0]          w_sum_next;

  assign w_accept   = rx_valid && rx_ready;
  assign w_sum_next = r_sum + rx_data;

`ifdef PROGMEM_PRIV_PROTECT_EN
  // Only bank 0 is writable without the unlock; pointer and checksum still advance.
  assign w_write_ok = (r_wptr[ADDR_W-1:ADDR_W-2] == 2'b00) || priv_unlock;
`else
  assign w_write_ok = 1'b1;
`endif

  assign data      = r_mem[addr];
  assign err       = r_err;
  assign cpu_reset = r_cpu_reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    rx_ready     = 1'b1;
    busy         = 1'b1;
    w_we         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept && rx_data == SYNC_BYTE) w_state_next = S_ADDR;
      end
      S_ADDR: if (w_accept) w_state_next = S_LEN;
      S_LEN:  if (w_accept) w_state_next = (rx_data == 8'd0) ? S_CSUM : S_DATA;
      S_DATA: begin
        if (w_accept) begin
          w_we = w_write_ok;
          if (r_cnt == 8'd1) w_state_next = S_CSUM;
        end
      end
      S_CSUM: if (w_accept) w_state_next = S_DONE;
      S_DONE: begin
        rx_ready     = 1'b0;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_err       <= 1'b0;
      r_cpu_reset <= 1'b1;
    end else begin
      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              r_err       <= 1'b0;
              r_cpu_reset <= 1'b0;
              r_sum       <= '0;
            end
          end
          S_ADDR: begin
            r_wptr <= rx_data[ADDR_W-1:0];
            r_sum  <= w_sum_next;
          end
          S_LEN: begin
            r_cnt <= rx_data;
            r_sum <= w_sum_next;
          end
          S_DATA: begin
            r_wptr <= r_wptr + ADDR_W'(1);
            r_cnt  <= r_cnt - 8'd1;
            r_sum  <= w_sum_next;
          end
          S_CSUM: if (w_sum_next != 8'd0) r_err <= 1'b1;
          default: ;
        endcase
      end
      // A bad frame leaves the cpu parked in reset until a good frame lands.
      if (r_state == S_DONE && !r_err) r_cpu_reset <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[r_wptr] <= DATA_W'(rx_data);
    end
  end

endmodule

`default_nettype wire

// File: doc/program_memory.md
Name: program_memory

Overview:
- Instruction-memory responder on the cpu fetch bus: takes cpu `addr` (phys, 6-bit: mode[1:0], addr[3:0]) and returns `data` (opcode[7:4], imm[3:0]) combinationally, in the same cycle.
- Also contains a byte-serial loader FSM. A host streams framed program images over a valid/ready byte interface.
- While a load is in progress, and after a failed load, the block holds the cpu in reset through `cpu_reset`.

Parameters:
- ADDR_W, 6, physical fetch address width; depth = 2**ADDR_W words.
- DATA_W, 8, instruction word width.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- addr  input  ADDR_W  cpu fetch address (addr_t phys_addr).
- data  output  DATA_W  instruction word at `addr` (data_t).
- rx_data  input  8  loader byte.
- rx_valid  input  1  `rx_data` valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- cpu_reset  output  1  active-low reset to cpu; registered.
- busy  output  1  frame in progress (state != IDLE).
- err  output  1  sticky checksum error; cleared at start of next frame.

Behaviour:
- Reset (async, reset==0) sets the following:
  - all memory words = 8'h00;
  - state = IDLE;
  - rx_ready = 1, busy = 0, err = 0;
  - cpu_reset = 1, so the cpu runs from word 0.
- Read port: `data = mem[addr]`, purely combinational, zero latency. During loads it shows the current array contents.
- Byte transfer: a byte is accepted only when rx_valid && rx_ready at a posedge.
  - rx_valid with rx_ready=0 is ignored, not queued.
  - The host must hold the byte until accepted.
- rx_ready = 1 in every state except DONE.
- FSM states: IDLE, ADDR, LEN, DATA, CSUM, DONE.
- IDLE: an accepted byte == SYNC_BYTE moves to ADDR. On that transition:
  - err <= 0;
  - cpu_reset <= 0;
  - sum <= 0.
  - Any other byte is dropped and the FSM stays in IDLE.
- ADDR: the accepted byte sets wptr <= byte[ADDR_W-1:0]. Upper bits are ignored but included in the checksum. sum += byte. Next state is LEN.
- LEN: the accepted byte sets cnt <= byte; sum += byte.
  - If byte == 0, go to CSUM; otherwise go to DATA.
  - cnt is 8-bit; counts above the depth wrap and overwrite earlier words.
- DATA: each accepted byte does the following:
  - mem[wptr] <= byte;
  - wptr <= wptr + 1, modulo 2**ADDR_W (wraps 63 -> 0);
  - sum += byte;
  - cnt -= 1.
  - When cnt == 1 at acceptance, the next state is CSUM.
- CSUM: for the accepted byte, if (sum + byte) mod 256 == 0 the frame is good; otherwise err <= 1. Next state is DONE.
- DONE (exactly one cycle, rx_ready = 0):
  - good frame: cpu_reset <= 1;
  - bad frame: cpu_reset stays 0.
  - Next state is IDLE.
- Data writes commit immediately and are not rolled back on a checksum error. The cpu stays in reset until a later good frame.
- cpu_reset timing: it is low from the cycle after SYNC acceptance through DONE. It goes high the cycle after DONE, only after a good frame.
- A SYNC_BYTE value received in ADDR, LEN, DATA or CSUM is treated as ordinary data; frames are not resynchronised.
- Reset asserted mid-frame aborts the frame:
  - memory is cleared;
  - the FSM returns to IDLE;
  - cpu_reset returns to 1.
- The sum accumulator is 8-bit and wraps.

Optional Feature:
- Macro PROGMEM_PRIV_PROTECT_EN.
- When defined:
  - an extra input port priv_unlock (1 bit) is added;
  - DATA-state writes where wptr[ADDR_W-1:ADDR_W-2] != 2'b00 (privileged banks) are suppressed unless priv_unlock == 1;
  - wptr, cnt and sum still advance, so the checksum covers the full frame.
- When not defined: no such port, and all addresses are writable.

Test Plan:
- Reset, then drive addr=6'h00 and addr=6'h3F -> data == 8'h00 both; cpu_reset == 1, busy == 0, rx_ready == 1, err == 0.
- Frame A5,00,03,B3,40,F0,1A -> mem[0..2] = B3,40,F0; cpu_reset low during frame; cpu_reset == 1 two cycles after checksum acceptance; err == 0.
- Frame A5,3F,02,11,22,8C -> mem[63] = 11 and mem[0] = 22 (address wrap); err == 0.
- Frame A5,05,01,77,00 (bad checksum) -> mem[5] = 77, err == 1, cpu_reset stays 0. Then a good frame A5,00,00,00 -> err == 0, cpu_reset == 1.
- Toggle rx_valid with gaps and hold a byte across the DONE cycle -> no byte is lost or duplicated; rx_ready == 0 only in DONE.
- With PROGMEM_PRIV_PROTECT_EN and priv_unlock = 0: frame A5,10,01,55,9A -> mem[16] stays 00, err == 0. Repeat with priv_unlock = 1 -> mem[16] = 55.
